// File: rtl/ram_partition_ctrl.sv
// ram_partition_ctrl
// Reconfiguration controller for a partitioned, power-gated RAM. Owns the
// per-partition gating vector. On a reconfiguration request it stalls the RAM
// users, applies the new gating, waits for newly ungated partitions to settle
// and re-initialises them through a dedicated write port.
//
// Ports
//   i_clk              clock, all state changes on the rising edge
//   i_rst_n            asynchronous active-low reset
//   i_reconfig         one-cycle request, samples i_part_enable (ignored while busy)
//   i_part_enable      requested enabled-partition mask (0 is coerced to partition 0)
//   i_stall_ack        users have drained and stopped accessing the RAM
//   i_ram_ready        per-partition ready from the RAM
//   o_partition_gated  1 = partition gated off
//   o_stall_req        users must stop accessing the RAM
//   o_init_wr_en       init write enable (parent muxes it onto write port 0)
//   o_init_addr        init address {part, entry}
//   o_init_data        init write data
//   o_busy             controller is not idle
//   o_reconfig_done    one-cycle pulse at the end of a reconfiguration
//   o_ready            idle and every enabled partition is ready
//
// State table
//   state   | meaning
//   S_IDLE  | normal operation, waiting for a request
//   S_DRAIN | stall requested, waiting for users to acknowledge
//   S_GATE  | new gating vector applied this cycle
//   S_WAKE  | settle time for newly ungated partitions
//   S_INIT  | one init write per cycle into newly ungated partitions
//   S_DONE  | completion pulse, stall released on leaving

module ram_partition_ctrl #(
   parameter int                   NUM_PARTS     = 4,
   parameter int                   NUM_PARTS_LOG = 2,
   parameter int                   PART_DEPTH    = 32,
   parameter int                   PART_INDEX    = 5,
   parameter int                   WIDTH         = 64,
   parameter logic [NUM_PARTS-1:0] RESET_MASK    = '1,
   parameter int                   WAKE_CYCLES   = 4,
   parameter bit                   RESET_SEQ     = 1'b0,
   parameter logic [63:0]          SEQ_START     = '0
) (
   input  logic                                i_clk,
   input  logic                                i_rst_n,
   input  logic                                i_reconfig,
   input  logic [NUM_PARTS-1:0]                i_part_enable,
   input  logic                                i_stall_ack,
   input  logic [NUM_PARTS-1:0]                i_ram_ready,
   output logic [NUM_PARTS-1:0]                o_partition_gated,
   output logic                                o_stall_req,
   output logic                                o_init_wr_en,
   output logic [NUM_PARTS_LOG+PART_INDEX-1:0] o_init_addr,
   output logic [WIDTH-1:0]                    o_init_data,
   output logic                                o_busy,
   output logic                                o_reconfig_done,
   output logic                                o_ready
);

   localparam int AW  = NUM_PARTS_LOG + PART_INDEX;
   localparam int WCW = $clog2(WAKE_CYCLES + 1);

   typedef enum logic [2:0] {
      S_IDLE, S_DRAIN, S_GATE, S_WAKE, S_INIT, S_DONE
   } state_t;

   state_t                   r_state;
   state_t                   w_state_nxt;
   logic [NUM_PARTS-1:0]     r_new_mask;
   logic [NUM_PARTS-1:0]     r_newly_on;
   logic [NUM_PARTS-1:0]     r_gated;
   logic [WCW-1:0]           r_wake_cnt;
   logic                     r_init_wr_en;
   logic [AW-1:0]            r_init_addr;
   logic [WIDTH-1:0]         r_init_data;

   logic [NUM_PARTS-1:0]     w_req_mask;
   logic                     w_wake_done;
   logic                     w_last_entry;
   logic [NUM_PARTS_LOG-1:0] w_cur_part;
   logic [NUM_PARTS_LOG-1:0] w_first_part;
   logic [NUM_PARTS_LOG-1:0] w_next_part;
   logic                     w_has_next;
   logic                     w_init_wr_en_nxt;
   logic [AW-1:0]            w_init_addr_nxt;
   logic [WIDTH-1:0]         w_init_data_nxt;

   // An empty mask would switch the whole RAM off; keep partition 0 alive.
   assign w_req_mask   = (i_part_enable == '0) ? NUM_PARTS'(1) : i_part_enable;
   assign w_wake_done  = (r_wake_cnt >= WCW'(WAKE_CYCLES - 1)) &&
                         (&(i_ram_ready | ~r_newly_on));
   assign w_cur_part   = r_init_addr[AW-1:PART_INDEX];
   assign w_last_entry = (r_init_addr[PART_INDEX-1:0] == PART_INDEX'(PART_DEPTH - 1));

   // Lowest newly-on partition, and lowest newly-on partition above the
   // one currently being written (descending scan, last hit wins).
   always_comb begin
      w_first_part = '0;
      w_next_part  = '0;
      w_has_next   = 1'b0;
      for (int p = NUM_PARTS - 1; p >= 0; p--) begin
         if (r_newly_on[p]) begin
            w_first_part = NUM_PARTS_LOG'(p);
            if (NUM_PARTS_LOG'(p) > w_cur_part) begin
               w_next_part = NUM_PARTS_LOG'(p);
               w_has_next  = 1'b1;
            end
         end
      end
   end

   // State register
   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) r_state <= S_IDLE;
      else          r_state <= w_state_nxt;
   end

   // Next-state logic
   always_comb begin
      w_state_nxt = r_state;
      case (r_state)
         S_IDLE:  if (i_reconfig)  w_state_nxt = S_DRAIN;
         S_DRAIN: if (i_stall_ack) w_state_nxt = S_GATE;
         S_GATE:  w_state_nxt = (r_newly_on != '0) ? S_WAKE : S_DONE;
         S_WAKE:  if (w_wake_done) w_state_nxt = S_INIT;
         S_INIT:  if (w_last_entry && !w_has_next) w_state_nxt = S_DONE;
         S_DONE:  w_state_nxt = S_IDLE;
         default: w_state_nxt = S_IDLE;
      endcase
   end

   // Outputs
   always_comb begin
      o_stall_req       = (r_state != S_IDLE);
      o_busy            = (r_state != S_IDLE);
      o_reconfig_done   = (r_state == S_DONE);
      o_ready           = (r_state == S_IDLE) && (&(i_ram_ready | r_gated));
      o_partition_gated = r_gated;
      o_init_wr_en      = r_init_wr_en;
      o_init_addr       = r_init_addr;
      o_init_data       = r_init_data;
   end

   // Init write generator: the address register doubles as the cursor.
   always_comb begin
      w_init_wr_en_nxt = 1'b0;
      w_init_addr_nxt  = '0;
      if (r_state == S_WAKE && w_wake_done) begin
         w_init_wr_en_nxt = 1'b1;
         w_init_addr_nxt  = {w_first_part, PART_INDEX'(0)};
      end else if (r_state == S_INIT) begin
         if (!w_last_entry) begin
            w_init_wr_en_nxt = 1'b1;
            w_init_addr_nxt  = r_init_addr + AW'(1);
         end else if (w_has_next) begin
            w_init_wr_en_nxt = 1'b1;
            w_init_addr_nxt  = {w_next_part, PART_INDEX'(0)};
         end
      end
      if (w_init_wr_en_nxt && RESET_SEQ)
         w_init_data_nxt = WIDTH'(SEQ_START + 64'(w_init_addr_nxt));
      else
         w_init_data_nxt = '0;
   end

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         r_new_mask   <= '0;
         r_newly_on   <= '0;
         r_gated      <= ~RESET_MASK;
         r_wake_cnt   <= '0;
         r_init_wr_en <= 1'b0;
         r_init_addr  <= '0;
         r_init_data  <= '0;
      end else begin
         if (r_state == S_IDLE && i_reconfig) begin
            r_new_mask <= w_req_mask;
            r_newly_on <= w_req_mask & r_gated;
         end
         // Turning off and on happens in the same edge as entry to GATE.
         if (r_state == S_DRAIN && i_stall_ack)
            r_gated <= ~r_new_mask;
         if (r_state == S_WAKE) begin
            if (r_wake_cnt < WCW'(WAKE_CYCLES - 1))
               r_wake_cnt <= r_wake_cnt + WCW'(1);
         end else begin
            r_wake_cnt <= '0;
         end
         r_init_wr_en <= w_init_wr_en_nxt;
         r_init_addr  <= w_init_addr_nxt;
         r_init_data  <= w_init_data_nxt;
      end
   end

endmodule

// File: tb/tb_ram_partition_ctrl.sv
// Bench for ram_partition_ctrl. Two instances share all inputs: one with the
// sequential init pattern (SEQ_START=0, data equals address) and one with
// zero fill. Expected behaviour is derived from a per-reconfiguration
// timeline (gate cycle, wake length, ordered write list).

module tb_ram_partition_ctrl;

   localparam int WK = 4;

   logic       clk = 1'b0;
   logic       rst_n = 1'b0;
   logic       reconfig = 1'b0;
   logic       stall_ack = 1'b0;
   logic [3:0] part_en = 4'h0;
   logic [3:0] ram_ready = 4'hF;

   logic [3:0]  gated [2];
   logic        stall [2];
   logic        wr_en [2];
   logic [6:0]  addr  [2];
   logic [63:0] data  [2];
   logic        busy  [2];
   logic        done  [2];
   logic        rdy   [2];

   int n_checks = 0;
   int n_err    = 0;
   logic [3:0] m_gated;

   always #5 clk = ~clk;

   ram_partition_ctrl #(.WAKE_CYCLES(WK), .RESET_SEQ(1'b1), .SEQ_START(64'd0)) u_seq (
      .i_clk(clk), .i_rst_n(rst_n), .i_reconfig(reconfig), .i_part_enable(part_en),
      .i_stall_ack(stall_ack), .i_ram_ready(ram_ready),
      .o_partition_gated(gated[0]), .o_stall_req(stall[0]), .o_init_wr_en(wr_en[0]),
      .o_init_addr(addr[0]), .o_init_data(data[0]), .o_busy(busy[0]),
      .o_reconfig_done(done[0]), .o_ready(rdy[0]));

   ram_partition_ctrl #(.WAKE_CYCLES(WK), .RESET_SEQ(1'b0)) u_zero (
      .i_clk(clk), .i_rst_n(rst_n), .i_reconfig(reconfig), .i_part_enable(part_en),
      .i_stall_ack(stall_ack), .i_ram_ready(ram_ready),
      .o_partition_gated(gated[1]), .o_stall_req(stall[1]), .o_init_wr_en(wr_en[1]),
      .o_init_addr(addr[1]), .o_init_data(data[1]), .o_busy(busy[1]),
      .o_reconfig_done(done[1]), .o_ready(rdy[1]));

   task automatic chk(input string name, input int d, input logic [63:0] act, input logic [63:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_err++;
         if (n_err <= 40)
            $display("FAIL %s dut%0d t=%0t: actual %0h required %0h", name, d, $time, act, exp);
      end
   endtask

   task automatic chk_idle(input string name, input logic [3:0] exp_g);
      for (int d = 0; d < 2; d++) begin
         chk({name, "_busy"},  d, 64'(busy[d]),  64'd0);
         chk({name, "_stall"}, d, 64'(stall[d]), 64'd0);
         chk({name, "_done"},  d, 64'(done[d]),  64'd0);
         chk({name, "_wr"},    d, 64'(wr_en[d]), 64'd0);
         chk({name, "_addr"},  d, 64'(addr[d]),  64'd0);
         chk({name, "_data"},  d, data[d],       64'd0);
         chk({name, "_gated"}, d, 64'(gated[d]), 64'(exp_g));
         chk({name, "_ready"}, d, 64'(rdy[d]),   64'(&(ram_ready | exp_g)));
      end
   endtask

   // One reconfiguration. a = DRAIN cycle in which stall_ack first goes high,
   // l = cycles after GATE during which newly enabled partitions report not ready.
   task automatic run_reconfig(input logic [3:0] mask, input int a, input int l, input bit poke,
                               input int rst_at, output int obs_done, output int obs_wr,
                               output logic [3:0] obs_gated);
      logic [3:0] nm, newly, old_g, exp_g;
      logic [6:0] q[$];
      logic [6:0] ea;
      int g, init_s, done_c;
      bit exp_wr, hit_rst;
      old_g = m_gated;
      nm    = (mask == 4'h0) ? 4'h1 : mask;
      newly = nm & old_g;
      for (int p = 0; p < 4; p++)
         if (newly[p])
            for (int e = 0; e < 32; e++) q.push_back(7'(p * 32 + e));
      g = a + 1;
      if (newly == 4'h0) begin
         init_s = g + 1;
         done_c = g + 1;
      end else begin
         init_s = ((WK > l) ? g + WK : g + l) + 1;
         done_c = init_s + q.size();
      end
      obs_done = -1;
      obs_wr   = 0;
      hit_rst  = 1'b0;
      @(negedge clk);
      reconfig  = 1'b1;
      part_en   = mask;
      stall_ack = 1'b0;
      for (int k = 1; k <= done_c + 3; k++) begin
         @(negedge clk);
         if (k == 1) begin
            reconfig = 1'b0;
            part_en  = 4'($urandom);
         end
         exp_wr = (newly != 4'h0) && (k >= init_s) && (k < done_c);
         ea     = exp_wr ? q[k - init_s] : 7'd0;
         exp_g  = (k >= g) ? ~nm : old_g;
         for (int d = 0; d < 2; d++) begin
            chk("busy",  d, 64'(busy[d]),  64'(k <= done_c));
            chk("stall", d, 64'(stall[d]), 64'(k <= done_c));
            chk("done",  d, 64'(done[d]),  64'(k == done_c));
            chk("gated", d, 64'(gated[d]), 64'(exp_g));
            chk("wr_en", d, 64'(wr_en[d]), 64'(exp_wr));
            chk("addr",  d, 64'(addr[d]),  64'(ea));
            chk("data",  d, data[d],       (d == 0) ? 64'(ea) : 64'd0);
            chk("ready", d, 64'(rdy[d]),   (k > done_c) ? 64'(&(ram_ready | ~nm)) : 64'd0);
         end
         if (done[0] && obs_done < 0) obs_done = k;
         if (wr_en[0]) obs_wr++;
         if (k == rst_at) begin
            rst_n = 1'b0;
            stall_ack = 1'b0;
            ram_ready = 4'hF;
            #1;
            chk_idle("async_rst", 4'h0);
            hit_rst = 1'b1;
            break;
         end
         stall_ack = (k >= a);
         ram_ready = (k < g + l) ? ~newly : 4'hF;
         if (poke) begin
            if (k == init_s + 5) begin
               reconfig = 1'b1;
               part_en  = 4'($urandom);
            end else if (k == init_s + 6) begin
               reconfig = 1'b0;
            end
         end
      end
      stall_ack = 1'b0;
      ram_ready = 4'hF;
      m_gated   = hit_rst ? 4'h0 : ~nm;
      obs_gated = gated[0];
   endtask

   typedef struct {
      logic [3:0] mask;
      int         ack;
      int         rdy_low;
      bit         poke;
      logic [3:0] exp_gated;
      int         exp_wr;
      int         exp_done;
   } vec_t;

   vec_t vt[7];

   initial begin
      #1000000;
      $display("FAIL watchdog: simulation did not complete");
      $fatal(1, "watchdog");
   end

   initial begin
      int od, ow;
      logic [3:0] og;

      //           mask  ack low poke gated  wr  done
      vt[0] = '{4'h3, 3, 0,  1'b0, 4'hC, 0,  5};   // shrink
      vt[1] = '{4'hF, 1, 0,  1'b0, 4'h0, 64, 71};  // grow 2->4, addr 64..127
      vt[2] = '{4'h1, 2, 0,  1'b0, 4'hE, 0,  4};
      vt[3] = '{4'h5, 1, 10, 1'b1, 4'hA, 32, 45};  // wake stretched, poke ignored
      vt[4] = '{4'h0, 1, 0,  1'b0, 4'hE, 0,  3};   // empty mask -> partition 0
      vt[5] = '{4'hA, 1, 3,  1'b0, 4'h5, 64, 71};  // parts 1 and 3, skip gap
      vt[6] = '{4'hF, 4, 0,  1'b0, 4'h0, 64, 74};

      rst_n     = 1'b0;
      ram_ready = 4'hF;
      repeat (3) @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);
      chk_idle("reset", 4'h0);
      m_gated = 4'h0;

      for (int i = 0; i < 7; i++) begin
         run_reconfig(vt[i].mask, vt[i].ack, vt[i].rdy_low, vt[i].poke, -1, od, ow, og);
         chk("tbl_done_cycle", i, 64'(od), 64'(vt[i].exp_done));
         chk("tbl_writes",     i, 64'(ow), 64'(vt[i].exp_wr));
         chk("tbl_gated",      i, 64'(og), 64'(vt[i].exp_gated));
      end

      for (int i = 0; i < 20; i++) begin
         run_reconfig(4'($urandom_range(0, 15)), $urandom_range(1, 4), $urandom_range(0, 9),
                      1'($urandom_range(0, 1)), -1, od, ow, og);
      end

      // Reset during the 20th init write of a grow 0x1 -> 0xF.
      run_reconfig(4'h1, 1, 0, 1'b0, -1, od, ow, og);
      chk("pre_rst_gated", 0, 64'(og), 64'hE);
      run_reconfig(4'hF, 1, 0, 1'b0, 26, od, ow, og);
      chk("rst_writes_seen", 0, 64'(ow), 64'd20);
      @(negedge clk);
      chk_idle("in_rst", 4'h0);
      rst_n = 1'b1;
      for (int k = 0; k < 3; k++) begin
         @(negedge clk);
         chk_idle("post_rst", 4'h0);
      end

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
      $finish;
   end

endmodule

// File: doc/ram_partition_ctrl.md
# ram_partition_ctrl

Reconfiguration controller for a partitioned, power-gated RAM. It owns the per-partition gating vector, so partitions can be switched on and off at run time. On each reconfiguration request it stalls the RAM's users and applies the new gating. Newly enabled partitions then get a wake-up delay and are re-initialised through a dedicated write port before the controller reports ready. It sits beside the partitioned RAM inside the owning structure (register file, issue queue, active list) and is driven by the core's reconfiguration logic.

## Interface
- NUM_PARTS, 4, number of RAM partitions
- NUM_PARTS_LOG, 2, log2(NUM_PARTS)
- PART_DEPTH, 32, entries per partition
- PART_INDEX, 5, log2(PART_DEPTH)
- WIDTH, 64, RAM data width
- RESET_MASK, all ones, partitions enabled out of reset
- WAKE_CYCLES, 4, minimum settle cycles after ungating (>=1)
- RESET_SEQ, 0, init pattern: 0 = zero fill, 1 = sequential
- SEQ_START, 0, base value for the sequential pattern
- clk  in  1  clock; all state changes on the rising edge
- reset  in  1  asynchronous, active-low reset
- reconfig_i  in  1  one-cycle request; samples partEnable_i
- partEnable_i  in  NUM_PARTS  requested enabled-partition mask
- stallAck_i  in  1  users have drained and stopped accessing the RAM
- ramReady_i  in  NUM_PARTS  per-partition ready from the RAM
- partitionGated_o  out  NUM_PARTS  1 = partition gated off
- stallReq_o  out  1  requests that users stop accessing the RAM
- initWrEn_o  out  1  init write enable; parent muxes it onto write port 0
- initAddr_o  out  NUM_PARTS_LOG+PART_INDEX  init address {part, entry}
- initData_o  out  WIDTH  init write data
- busy_o  out  1  FSM is not in IDLE
- reconfigDone_o  out  1  one-cycle pulse at the end of a reconfiguration
- ready_o  out  1  IDLE and every enabled partition is ready

## Operation
- Reset values: partitionGated_o=~RESET_MASK. All other outputs are 0. FSM=IDLE, counters=0.
- States: IDLE, DRAIN, GATE, WAKE, INIT, DONE.
- IDLE: on reconfig_i, latch newMask=partEnable_i and go to DRAIN. If partEnable_i==0, newMask is coerced to 1 (partition 0 enabled). Compute newlyOn = newMask & partitionGated_o.
- DRAIN: stallReq_o=1. Go to GATE on the first cycle stallAck_i=1.
- GATE (1 cycle): partitionGated_o <= ~newMask, registered on entry. Partitions being turned off and on switch simultaneously. Next state is WAKE if newlyOn!=0, else DONE.
- WAKE: wake counter runs from 0. Exit to INIT when count >= WAKE_CYCLES-1 and ramReady_i is 1 for all bits of newlyOn. WAKE lasts WAKE_CYCLES cycles minimum and is extended while any such ramReady_i bit is low.
- INIT: one write per cycle. Partitions in newlyOn are visited in ascending index order; entries go 0..PART_DEPTH-1 within each. initAddr_o={part, entry}. initData_o is 0 (RESET_SEQ=0) or SEQ_START+initAddr_o, zero-extended or truncated to WIDTH (RESET_SEQ=1). Enabled partitions not in newlyOn are not written. After the last entry of the highest newlyOn partition, go to DONE.
- DONE (1 cycle): reconfigDone_o=1, then IDLE. stallReq_o drops on entry to IDLE.
- stallReq_o is 1 in DRAIN, GATE, WAKE, INIT and DONE.
- initWrEn_o/initAddr_o/initData_o are registered, valid only in INIT, and 0 elsewhere.
- reconfig_i while busy_o=1 is ignored (not queued).
- ready_o = IDLE && &(ramReady_i | partitionGated_o).
- Asynchronous reset at any point, including mid-INIT, returns everything to reset values immediately. No further writes are issued.

## Timing
- reconfig_i high at edge T → DRAIN at T+1, stallReq_o=1 visible from T+1.
- stallAck_i high in DRAIN cycle D → GATE at D+1, with the new partitionGated_o visible in that cycle.
- If newlyOn=0: DONE at D+2, IDLE at D+3.
- If newlyOn!=0: WAKE at D+2 through D+1+WAKE_CYCLES (with ramReady_i held), then INIT for popcount(newlyOn)*PART_DEPTH cycles, then DONE for 1 cycle, then IDLE.
- Writes land in the RAM one cycle after initWrEn_o (write-port latency). The last write completes before stallReq_o drops.

## Test plan
- Reset with ramReady_i=4'hF → partitionGated_o=4'b0000, busy_o=0, stallReq_o=0, ready_o=1 on the first post-reset cycle.
- Shrink: reconfig_i with partEnable_i=4'h3 at T, stallAck_i high at T+3 → GATE at T+4 with partitionGated_o=4'b1100, no initWrEn_o, reconfigDone_o at T+5, busy_o=0 at T+6.
- Grow, RESET_SEQ=1, SEQ_START=0: 4'h3→4'hF, stallAck_i immediate → 4 WAKE cycles, then 64 consecutive writes with addr 64..127 and data=addr, then reconfigDone_o once.
- WAKE extension: hold ramReady_i[2]=0 for 10 cycles after GATE → INIT starts only after ramReady_i[2] rises; zero-fill data=0.
- reconfig_i pulsed in INIT → ignored, mask unchanged. Then partEnable_i=0 from IDLE → partitionGated_o=4'b1110.
- Drop reset to 0 at the 20th INIT write → initWrEn_o=0, stallReq_o=0, partitionGated_o=~RESET_MASK immediately, FSM=IDLE after release.
